// File: rtl/des_sync_if.sv
// des_sync_if: serial-in / parallel-out bus between a bit source/consumer and des_sync
interface des_sync_if;
    logic       data_in;
    logic       bit_en;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       sync_seen;
    logic       lock_lost;
    logic       overrun;

    // Source/consumer side: drives serial bits and the ready handshake
    modport master (
        output data_in, bit_en, data_ready,
        input  data_out, data_valid, locked, sync_seen, lock_lost, overrun
    );

    // Deframer side
    modport slave (
        input  data_in, bit_en, data_ready,
        output data_out, data_valid, locked, sync_seen, lock_lost, overrun
    );
endinterface

// File: rtl/des_sync.sv
// des_sync: serial deframer that hunts for a sync word, then delivers aligned bytes
module des_sync #(
    parameter logic [7:0]  SYNC_WORD = 8'hA5,
    parameter int unsigned MAX_GAP   = 16
) (
    input  logic        clock_ser,
    input  logic        reset,
    des_sync_if.slave   bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [7:0] GAP_LIM = 8'(MAX_GAP);

    state_t     state_q;
    logic [7:0] sr_q;
    logic [7:0] sr_d;
    logic [2:0] bit_cnt_q;
    logic [7:0] gap_q;
    logic [7:0] gap_d;
    logic [7:0] data_out_q;
    logic       data_valid_q;
    logic       locked_q;
    logic       sync_seen_q;
    logic       lock_lost_q;
    logic       overrun_q;

    // Bits arrive LSB first, so each new bit enters at the top and slides down
    assign sr_d  = {bus.data_in, sr_q[7:1]};
    assign gap_d = gap_q + 8'd1;

    // Framing FSM, word assembly, gap timeout and output handshake in one register stage
    always_ff @(posedge clock_ser or posedge reset) begin
        if (reset) begin
            state_q      <= HUNT;
            sr_q         <= 8'h00;
            bit_cnt_q    <= 3'd0;
            gap_q        <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_seen_q  <= 1'b0;
            lock_lost_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_seen_q <= 1'b0;
            lock_lost_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (data_valid_q && bus.data_ready) data_valid_q <= 1'b0;
            if (bus.bit_en) begin
                sr_q <= sr_d;
                if (state_q == HUNT) begin
                    if (sr_d == SYNC_WORD) begin
                        state_q   <= LOCKED;
                        locked_q  <= 1'b1;
                        bit_cnt_q <= 3'd0;
                        gap_q     <= 8'h00;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (sr_d == SYNC_WORD) begin
                            sync_seen_q <= 1'b1;
                            gap_q       <= 8'h00;
                        end else begin
                            gap_q <= gap_d;
                            // A same-edge accept frees the slot, so the new word may load
                            if (!data_valid_q || bus.data_ready) begin
                                data_out_q   <= sr_d;
                                data_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            if (gap_d == GAP_LIM) begin
                                state_q     <= HUNT;
                                locked_q    <= 1'b0;
                                lock_lost_q <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.locked     = locked_q;
    assign bus.sync_seen  = sync_seen_q;
    assign bus.lock_lost  = lock_lost_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: doc/des_sync.md
DES_SYNC -- requirements
Module: des_sync

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5; 8-bit framing pattern; 8'h00 and 8'hFF are illegal values.
REQ-002 Parameter MAX_GAP, default 16; frames allowed without a sync word before lock is dropped; legal range 1..255.
REQ-003 clock_ser  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 data_in  input  1  serial bit stream, LSB of each word first.
REQ-006 bit_en  input  1  qualifies data_in; a bit is accepted only on an edge where bit_en=1.
REQ-007 data_out  output  8  last delivered parallel word, registered.
REQ-008 data_valid  output  1  data_out holds an undelivered word.
REQ-009 data_ready  input  1  consumer accepts data_out on an edge where data_valid=1 and data_ready=1.
REQ-010 locked  output  1  block is frame-aligned, i.e. in state LOCKED.
REQ-011 sync_seen  output  1  one-cycle pulse; a sync word was received while LOCKED.
REQ-012 lock_lost  output  1  one-cycle pulse; lock dropped on gap timeout.
REQ-013 overrun  output  1  one-cycle pulse; a completed word was discarded because data_valid=1 and data_ready=0.

Function
REQ-014 The block shall keep an 8-bit shift register sr, updated per accepted bit as sr <= {data_in, sr[7:1]}; an edge with bit_en=0 shall leave all state unchanged, except data_valid clearing on a consumer accept.
REQ-015 The block shall use a two-state FSM: HUNT and LOCKED.
REQ-016 In HUNT, on each accepted bit, if the updated sr value equals SYNC_WORD, the block shall go to LOCKED, clear the bit counter to 0, and clear the gap counter to 0.
REQ-017 In HUNT, the block shall deliver no data and shall not pulse sync_seen.
REQ-018 In LOCKED, a 3-bit bit counter shall increment per accepted bit and wrap from 7 to 0; the accepted bit that occurs at count 7 completes a word equal to the updated sr.
REQ-019 If a completed word equals SYNC_WORD, the block shall pulse sync_seen, clear the gap counter, and not deliver the word.
REQ-020 If a completed word differs from SYNC_WORD, the block shall deliver it and increment the gap counter.
REQ-021 When the gap counter reaches MAX_GAP on a word completion, the block shall return to HUNT and pulse lock_lost; that last word shall still be delivered.
REQ-022 Delivery latency: data_out and data_valid shall update on the same edge that samples the 8th bit, visible the following cycle.
REQ-023 data_valid shall remain 1 and data_out stable until a consumer accept edge.
REQ-024 Simultaneous accept and word completion on the same edge: the new word shall load, data_valid shall stay 1, and no overrun shall occur.
REQ-025 Word completion while data_valid=1 and data_ready=0: the new word shall be dropped, data_out shall be unchanged, and overrun shall pulse.
REQ-026 data_ready shall be ignored while data_valid=0.
REQ-027 locked shall equal (state == LOCKED), registered.
REQ-028 All pulse outputs shall be high for exactly one cycle per event.

Reset
REQ-029 While reset=1, asynchronously: sr=0, state=HUNT, bit counter=0, gap counter=0, data_out=8'h00, data_valid=0, locked=0, sync_seen=0, lock_lost=0, overrun=0.
REQ-030 Reset asserted mid-word or mid-handshake shall discard the pending word and partial bits; after release the block shall hunt from scratch.

Verification
REQ-031 Lock acquire: after reset, send bits 0,1,1 then SYNC_WORD A5 LSB-first, then 3C -> locked=1 the cycle after the last sync bit; data_out=3C with data_valid=1 one cycle after its 8th bit; no sync_seen pulse.
REQ-032 Sync filtering: locked; send 5A, A5, C3 with data_ready=1 -> deliveries are 5A then C3 only; exactly one sync_seen pulse, on the A5 frame.
REQ-033 Gap timeout: MAX_GAP=4; lock, then send 4 non-sync words -> all 4 delivered; lock_lost pulse and locked=0 after the 4th; subsequent words are not delivered until SYNC_WORD is seen again.
REQ-034 Backpressure: data_ready=0; send 11 then 22 -> data_out stays 11 and overrun pulses once at the end of 22; raise data_ready -> data_valid clears next cycle.
REQ-035 Same-edge accept: data_ready=1 asserted on the 8th-bit edge of the next word -> no overrun, data_valid stays 1, new word visible.
REQ-036 Gaps and reset: run with bit_en toggling 1/0 -> words are identical to the continuous-bit case; assert reset mid-word -> all outputs are 0 asynchronously, and re-lock requires a fresh SYNC_WORD.
